// File: rtl/vram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// vram_rr_arbiter
//
// Round-robin arbiter for the 16 pixel/sprite clients that share the 19-bit
// VRAM address path. The one-hot grant drives the select input of the
// downstream 16-way address mux. A grant is held for one memory transaction
// and is then released. After a release, priority rotates to the client that
// follows the one just served.
//
// State table:
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant; search req from ptr (wrapping 15->0) for next client
//   BUSY  | grant held; wait for done, request drop or hold timeout
//
// Ports:
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   req[15:0]   in   request lines, req[k]=1 -> client k wants VRAM
//   done        in   one-cycle pulse: current transaction complete
//   grant[15:0] out  registered one-hot grant, all-zero when idle
//   grant_valid out  registered, 1 exactly when grant is non-zero
//   grant_idx   out  registered binary index of granted client, 0 when idle
//   timeout     out  registered one-cycle pulse on a forced release
//
// When grant is all-zero the downstream mux still passes in15. Consumers
// must therefore qualify on grant_valid, and never on the mux output alone.
// ---------------------------------------------------------------------------
module vram_rr_arbiter #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 10
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic        grant_valid,
    output logic [3:0]  grant_idx,
    output logic        timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [3:0]         ptr;
    logic [CNT_W-1:0]   hold_cnt;

    logic               pick_found;
    logic [3:0]         pick_idx;
    logic [3:0]         cand;

    logic               rel_done;
    logic               rel_drop;
    logic               rel_tmo;
    logic               release_now;

    // Rotating priority search. The first set request at or after ptr
    // wins. The 4-bit wrap of ptr + i gives the 15->0 wraparound.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 4'd0;
        cand       = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr + 4'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Release causes while BUSY, in priority order: done, request drop,
    // hold limit. Only the hold limit alone counts as a timeout.
    assign rel_done    = done;
    assign rel_drop    = ~req[grant_idx];
    assign rel_tmo     = (hold_cnt == CNT_W'(TIMEOUT - 1));
    assign release_now = rel_done | rel_drop | rel_tmo;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ptr         <= 4'd0;
            hold_cnt    <= '0;
            grant       <= 16'h0000;
            grant_valid <= 1'b0;
            grant_idx   <= 4'd0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout  <= 1'b0;
                    hold_cnt <= '0;
                    if (pick_found) begin
                        grant       <= 16'h0001 << pick_idx;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        // Dropping through IDLE forces the one-cycle
                        // all-zero gap between consecutive grants.
                        grant       <= 16'h0000;
                        grant_valid <= 1'b0;
                        grant_idx   <= 4'd0;
                        ptr         <= grant_idx + 4'd1;
                        hold_cnt    <= '0;
                        timeout     <= ~rel_done & ~rel_drop;
                        state       <= IDLE;
                    end else begin
                        timeout <= 1'b0;
                        if (hold_cnt != CNT_W'(TIMEOUT))
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= 16'h0000;
                    grant_valid <= 1'b0;
                    grant_idx   <= 4'd0;
                    timeout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vram_rr_arbiter.md
Name: vram_rr_arbiter

Overview:
- Round-robin arbiter that grants 16 pixel/sprite clients access to the shared 19-bit VRAM address path.
- Sits directly upstream of the 16-way 19-bit address select mux. Its one-hot grant vector drives that mux's 16-bit select input, and client k's address feeds mux input k.
- Holds a grant for one memory transaction, then rotates priority so every client is served fairly.

Parameters:
- TIMEOUT, 1023, maximum cycles a grant may be held before forced release; must satisfy 1 ≤ TIMEOUT ≤ 1023.
- CNT_W, 10, width of the hold counter; must be wide enough to hold TIMEOUT.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req  input  16  request lines; req[k]=1 means client k wants VRAM.
- done  input  1  one-cycle pulse from memory side: current transaction complete.
- grant  output  16  registered one-hot grant; drives the downstream mux select. It is all-zero when idle.
- grant_valid  output  1  registered; 1 exactly when grant is non-zero.
- grant_idx  output  4  registered binary index of the granted client; 0 when idle.
- timeout  output  1  registered one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (resetn=0, asynchronous):
  - grant=0, grant_valid=0, grant_idx=0, timeout=0.
  - ptr=0, hold counter=0, state=IDLE.
  - Reset mid-grant drops grant immediately, with no waiting for a clock edge.
- All-zero grant:
  - The downstream mux passes in15 when its select is all-zero.
  - Consumers must qualify on grant_valid.
  - Client 15's access is valid only when grant[15]=1.
- State IDLE:
  - grant=0.
  - Search req starting at ptr, wrapping 15→0, and pick the first set bit k.
  - If one is found: on the next edge grant=1<<k, grant_idx=k, grant_valid=1, counter=0, state=BUSY.
  - If req=0: stay in IDLE.
  - Latency: req asserted in cycle n → grant visible in cycle n+1.
- State BUSY:
  - grant, grant_idx and grant_valid are held constant; changes on other req bits are ignored.
  - Counter increments each cycle, saturating at TIMEOUT.
  - Release conditions, evaluated each edge in this priority order:
    - (a) done=1
    - (b) req[grant_idx]=0
    - (c) counter==TIMEOUT-1
  - On any release: next edge grant=0, grant_valid=0, grant_idx=0, ptr=(grant_idx+1) mod 16, state=IDLE.
  - timeout=1 for that one cycle only if (c) caused the release and neither (a) nor (b) was true.
- Minimum gap: at least one all-zero grant cycle between consecutive grants, even with continuous requests. This guarantees the downstream address never switches between two clients without an idle cycle.
- done while IDLE is ignored.
- done and request drop in the same cycle: treated as a normal release; timeout=0.
- Fairness: with all 16 req held high, grants cycle 0,1,…,15,0 in order. Each client waits at most 15 other grants.
- ptr wraps 15→0. Grant index 15 sets ptr=0.
- grant is always either zero or exactly one bit set; never multiple bits.

Test Plan:
- Reset, then req=16'h0000 for 10 cycles → grant=0, grant_valid=0, grant_idx=0, timeout=0 throughout. Assert resetn low mid-BUSY → grant=0 without a clock edge.
- From reset, req=16'h0010 at cycle n → grant=16'h0010, grant_idx=4 at n+1. Pulse done at n+3 → grant=0 at n+4. Keep req[4] high → grant=16'h0010 again at n+5.
- req=16'hFFFF held, done pulsed every grant cycle → grant_idx sequence 0,1,2,…,15,0 with exactly one zero-grant cycle between each; never two bits set.
- After a grant to client 15, req=16'h8001 → next grant is client 0 (ptr wrapped). Then req=16'h8000 → client 15.
- TIMEOUT=8, req=16'h0100 held, no done → grant_idx=8 for exactly 8 cycles, then timeout=1 for one cycle with grant=0. Next grant is client 8 again, as the only requester.
- Client 3 granted, req[3] drops and done=1 in the same cycle → release next edge with timeout=0. Meanwhile req[9] toggling during BUSY leaves the grant unchanged.
